// File: rtl/inbound_dma_ctrl.sv
// Inbound DMA control block: per-channel doorbell/length/address registers,
// round-robin doorbell arbitration and completion interleaving into the
// upstream command FIFO.
`timescale 1ns/1ps
module inbound_dma_ctrl #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEF_LEN = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_wr_cmd_compl_i,
  input  logic [2:0]   cmd_id_i,
  input  logic         req_compl_i,
  input  logic         req_compl_with_data_i,
  output logic         to_rxe_compl_done_o,
  input  logic [10:0]  rd_addr_i,
  output logic [31:0]  rd_data_o,
  input  logic [10:0]  wr_addr_i,
  input  logic [7:0]   wr_be_i,
  input  logic [31:0]  wr_data_i,
  input  logic         wr_en_i,
  output logic         wr_busy_o,
  input  logic [2:0]   req_tc_i,
  input  logic         req_td_i,
  input  logic         req_ep_i,
  input  logic [1:0]   req_attr_i,
  input  logic [9:0]   req_len_i,
  input  logic [15:0]  req_rid_i,
  input  logic [7:0]   req_tag_i,
  input  logic [7:0]   req_be_i,
  input  logic [12:0]  req_addr_i,
  input  logic         us_cmd_fifo_full_i,
  input  logic         us_cmd_fifo_prog_full_i,
  output logic [127:0] us_cmd_fifo_din_o,
  output logic         us_cmd_fifo_wr_en_o
);

  localparam int unsigned CH_W  = 3;
  localparam int unsigned CPL_W = 55;
  localparam logic [1:0] TYPE_WR   = 2'd1;
  localparam logic [1:0] TYPE_CPL  = 2'd2;
  localparam logic [1:0] TYPE_CPLD = 2'd3;

  typedef enum logic [1:0] {IDLE, CPL_WAIT, CPL_ISSUE, CMD_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d, busy_q, busy_d;
  logic [4:0]          len_q, len_d;
  logic [31:0]         addr_lo_q [NUM_CH];
  logic [31:0]         addr_lo_d [NUM_CH];
  logic [31:0]         addr_hi_q [NUM_CH];
  logic [31:0]         addr_hi_d [NUM_CH];
  logic [CH_W-1:0]     rr_q, rr_d, grant_q, grant_d;
  logic [CPL_W-1:0]    cpl_q, cpl_d;
  logic                cpld_q, cpld_d;
  logic                push_q, push_d, done_q, done_d, wbusy_q, wbusy_d;
  logic [127:0]        din_q, din_d;

  logic [4:0]          wr_idx, rd_idx;
  logic [NUM_CH-1:0]   clr, db_set, gnt_oh;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_id;
  logic [63:0]         wr_payload;
  logic                unused_ok;

  assign wr_idx    = wr_addr_i[6:2];
  assign rd_idx    = rd_addr_i[6:2];
  assign unused_ok = ^{wr_be_i, rd_addr_i[10:7], rd_addr_i[1:0],
                       wr_addr_i[10:7], wr_addr_i[1:0], req_addr_i[12:6]};

  assign us_cmd_fifo_wr_en_o = push_q;
  assign us_cmd_fifo_din_o   = din_q;
  assign to_rxe_compl_done_o = done_q;
  assign wr_busy_o           = wbusy_q;

  // Register updates, round-robin grant, FSM next state and next FIFO word
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    len_d      = len_q;
    addr_lo_d  = addr_lo_q;
    addr_hi_d  = addr_hi_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    cpl_d      = cpl_q;
    cpld_d     = cpld_q;
    push_d     = 1'b0;
    done_d     = 1'b0;
    din_d      = '0;
    clr        = '0;
    db_set     = '0;
    gnt_oh     = '0;
    gnt_found  = 1'b0;
    gnt_id     = '0;
    wr_payload = '0;

    // completion clears busy before the doorbell is evaluated
    for (int j = 0; j < int'(NUM_CH); j++)
      if (up_wr_cmd_compl_i && cmd_id_i == CH_W'(j)) clr[j] = 1'b1;
    busy_d = busy_q & ~clr;

    if (wr_en_i) begin
      if (wr_idx == 5'd0) db_set = wr_data_i[NUM_CH-1:0] & ~busy_d & ~pending_q;
      if (wr_idx == 5'd1) len_d = wr_data_i[4:0];
      for (int j = 0; j < int'(NUM_CH); j++) begin
        if (wr_idx == 5'(8 + 2*j)) addr_lo_d[j] = wr_data_i;
        if (ADDR_W == 64 && wr_idx == 5'(9 + 2*j)) addr_hi_d[j] = wr_data_i;
      end
    end
    pending_d = pending_q | db_set;

    // first pending channel strictly after rr pointer, wrapping
    for (int j = 0; j < int'(NUM_CH); j++)
      if (!gnt_found && pending_q[j] && CH_W'(j) > rr_q) begin
        gnt_found = 1'b1;
        gnt_id    = CH_W'(j);
        gnt_oh[j] = 1'b1;
      end
    for (int j = 0; j < int'(NUM_CH); j++)
      if (!gnt_found && pending_q[j] && CH_W'(j) <= rr_q) begin
        gnt_found = 1'b1;
        gnt_id    = CH_W'(j);
        gnt_oh[j] = 1'b1;
      end
    for (int j = 0; j < int'(NUM_CH); j++)
      if (gnt_oh[j])
        wr_payload = (ADDR_W == 64) ? {addr_hi_q[j], addr_lo_q[j]} : {32'd0, addr_lo_q[j]};

    case (state_q)
      IDLE: begin
        if (req_compl_i) begin
          cpl_d   = {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i,
                     req_rid_i, req_tag_i, req_be_i, req_addr_i[5:0]};
          cpld_d  = req_compl_with_data_i;
          state_d = us_cmd_fifo_full_i ? CPL_WAIT : CPL_ISSUE;
        end else if (gnt_found && !us_cmd_fifo_prog_full_i) begin
          pending_d = pending_d & ~gnt_oh;
          busy_d    = busy_d | gnt_oh;
          rr_d      = gnt_id;
          grant_d   = gnt_id;
          state_d   = CMD_ISSUE;
        end
      end
      CPL_WAIT:  if (!us_cmd_fifo_full_i) state_d = CPL_ISSUE;
      CPL_ISSUE: state_d = IDLE;
      CMD_ISSUE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    wbusy_d = (state_d != IDLE);
    if (state_d == CPL_ISSUE) begin
      push_d = 1'b1;
      done_d = 1'b1;
      din_d  = {54'd0, 3'd0, len_q, (cpld_d ? TYPE_CPLD : TYPE_CPL), 9'd0, cpl_d};
    end else if (state_d == CMD_ISSUE) begin
      push_d = 1'b1;
      din_d  = {54'd0, grant_d, len_q, TYPE_WR, wr_payload};
    end
  end

  // State and register flops; reset drops any push in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      busy_q    <= '0;
      len_q     <= 5'(DEF_LEN);
      for (int j = 0; j < int'(NUM_CH); j++) begin
        addr_lo_q[j] <= '0;
        addr_hi_q[j] <= '0;
      end
      rr_q      <= CH_W'(NUM_CH - 1);
      grant_q   <= '0;
      cpl_q     <= '0;
      cpld_q    <= 1'b0;
      push_q    <= 1'b0;
      done_q    <= 1'b0;
      wbusy_q   <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      len_q     <= len_d;
      addr_lo_q <= addr_lo_d;
      addr_hi_q <= addr_hi_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      cpl_q     <= cpl_d;
      cpld_q    <= cpld_d;
      push_q    <= push_d;
      done_q    <= done_d;
      wbusy_q   <= wbusy_d;
      din_q     <= din_d;
    end
  end

  // Combinational register read mux
  always_comb begin
    rd_data_o = '0;
    case (rd_idx)
      5'd0, 5'd3: rd_data_o = 32'(pending_q);
      5'd1:       rd_data_o = 32'(len_q);
      5'd2:       rd_data_o = 32'(busy_q);
      default: begin
        for (int j = 0; j < int'(NUM_CH); j++) begin
          if (rd_idx == 5'(8 + 2*j)) rd_data_o = addr_lo_q[j];
          if (ADDR_W == 64 && rd_idx == 5'(9 + 2*j)) rd_data_o = addr_hi_q[j];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_inbound_dma_ctrl.sv
// Testbench for inbound_dma_ctrl: register map vectors plus directed
// sequences for arbitration, completions, races and mid-operation reset.
`timescale 1ns/1ps
module tb_inbound_dma_ctrl;

  logic         clk, rst;
  logic         up_wr_cmd_compl_i;
  logic [2:0]   cmd_id_i;
  logic         req_compl_i, req_compl_with_data_i, to_rxe_compl_done_o;
  logic [10:0]  rd_addr_i, wr_addr_i;
  logic [31:0]  rd_data_o, wr_data_i;
  logic [7:0]   wr_be_i;
  logic         wr_en_i, wr_busy_o;
  logic [2:0]   req_tc_i;
  logic         req_td_i, req_ep_i;
  logic [1:0]   req_attr_i;
  logic [9:0]   req_len_i;
  logic [15:0]  req_rid_i;
  logic [7:0]   req_tag_i, req_be_i;
  logic [12:0]  req_addr_i;
  logic         us_cmd_fifo_full_i, us_cmd_fifo_prog_full_i;
  logic [127:0] us_cmd_fifo_din_o;
  logic         us_cmd_fifo_wr_en_o;

  inbound_dma_ctrl #(.NUM_CH(4), .ADDR_W(32), .DEF_LEN(6)) dut (
    .clk(clk), .rst(rst),
    .up_wr_cmd_compl_i(up_wr_cmd_compl_i), .cmd_id_i(cmd_id_i),
    .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
    .to_rxe_compl_done_o(to_rxe_compl_done_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .wr_en_i(wr_en_i), .wr_busy_o(wr_busy_o),
    .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
    .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
    .req_tag_i(req_tag_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i),
    .us_cmd_fifo_full_i(us_cmd_fifo_full_i),
    .us_cmd_fifo_prog_full_i(us_cmd_fifo_prog_full_i),
    .us_cmd_fifo_din_o(us_cmd_fifo_din_o),
    .us_cmd_fifo_wr_en_o(us_cmd_fifo_wr_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int din_bad = 0;
  logic [127:0] pq[$];

  // capture every pushed word; flag a nonzero word without a push
  always @(negedge clk) begin
    if (!rst && us_cmd_fifo_wr_en_o) pq.push_back(us_cmd_fifo_din_o);
    if (!us_cmd_fifo_wr_en_o && us_cmd_fifo_din_o != 128'd0) din_bad++;
  end

  typedef struct {
    bit          wr;
    logic [10:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_addr_i = a; wr_data_i = d; wr_en_i = 1'b1;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [10:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_addr_i = a;
    #1 d = rd_data_o;
  endtask

  task automatic compl(input logic [2:0] id);
    @(negedge clk);
    up_wr_cmd_compl_i = 1'b1; cmd_id_i = id;
    @(negedge clk);
    up_wr_cmd_compl_i = 1'b0;
  endtask

  task automatic wait_pushes(input int n, input string nm);
    int cyc = 0;
    while (pq.size() < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, 128'(pq.size()), 128'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pq.delete();
  endtask

  logic [31:0]  rd;
  logic [54:0]  cpl_fields;
  logic [127:0] exp_word;

  initial begin
    rst = 1'b1;
    up_wr_cmd_compl_i = 0; cmd_id_i = 0; req_compl_i = 0; req_compl_with_data_i = 0;
    rd_addr_i = 0; wr_addr_i = 0; wr_data_i = 0; wr_be_i = 8'hFF; wr_en_i = 0;
    req_tc_i = 3'h5; req_td_i = 1'b1; req_ep_i = 1'b0; req_attr_i = 2'b10;
    req_len_i = 10'h155; req_rid_i = 16'hABCD; req_tag_i = 8'h3C; req_be_i = 8'hF0;
    req_addr_i = 13'h1A7;
    us_cmd_fifo_full_i = 0; us_cmd_fifo_prog_full_i = 0;

    tbl[0]  = '{0, 11'h004, 32'h6,        "rst_len"};
    tbl[1]  = '{0, 11'h008, 32'h0,        "rst_busy"};
    tbl[2]  = '{0, 11'h00C, 32'h0,        "rst_pending"};
    tbl[3]  = '{0, 11'h020, 32'h0,        "rst_addr0"};
    tbl[4]  = '{0, 11'h000, 32'h0,        "rst_doorbell"};
    tbl[5]  = '{1, 11'h020, 32'hDEADBEEF, ""};
    tbl[6]  = '{0, 11'h020, 32'hDEADBEEF, "addr_lo0"};
    tbl[7]  = '{0, 11'h420, 32'hDEADBEEF, "addr_upper_bits_ignored"};
    tbl[8]  = '{1, 11'h024, 32'h12345678, ""};
    tbl[9]  = '{0, 11'h024, 32'h0,        "addr_hi0_32b"};
    tbl[10] = '{1, 11'h004, 32'h000001F3, ""};
    tbl[11] = '{0, 11'h004, 32'h13,       "len_5bit"};
    tbl[12] = '{1, 11'h004, 32'h6,        ""};
    tbl[13] = '{1, 11'h010, 32'h55,       ""};
    tbl[14] = '{0, 11'h010, 32'h0,        "unmapped_idx4"};
    tbl[15] = '{1, 11'h038, 32'hCAFE0000, ""};
    tbl[16] = '{0, 11'h038, 32'hCAFE0000, "addr_lo3"};
    tbl[17] = '{1, 11'h040, 32'h11111111, ""};
    tbl[18] = '{0, 11'h040, 32'h0,        "out_of_range_idx16"};
    tbl[19] = '{0, 11'h07C, 32'h0,        "unmapped_idx31"};
    tbl[20] = '{0, 11'h004, 32'h6,        "len_restored"};

    do_reset();
    chk("rst_push", 128'(us_cmd_fifo_wr_en_o), 128'd0);
    chk("rst_wr_busy", 128'(wr_busy_o), 128'd0);
    chk("rst_din", us_cmd_fifo_din_o, 128'd0);

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].wr) reg_wr(tbl[i].addr, tbl[i].data);
      else begin
        reg_rd(tbl[i].addr, rd);
        chk(tbl[i].name, 128'(rd), 128'(tbl[i].data));
      end
    end

    // single channel issue with latency check
    pq.delete();
    reg_wr(11'h028, 32'h1000_0000);
    reg_wr(11'h000, 32'h2);
    chk("db_no_push_yet", 128'(us_cmd_fifo_wr_en_o), 128'd0);
    @(negedge clk);
    chk("db_push", 128'(us_cmd_fifo_wr_en_o), 128'd1);
    exp_word = {54'd0, 3'd1, 5'd6, 2'd1, 32'd0, 32'h1000_0000};
    chk("db_word_ch1", us_cmd_fifo_din_o, exp_word);
    @(negedge clk);
    chk("db_push_one_cycle", 128'(us_cmd_fifo_wr_en_o), 128'd0);
    reg_rd(11'h008, rd); chk("busy_after_issue", 128'(rd), 128'h2);
    reg_rd(11'h00C, rd); chk("pending_after_issue", 128'(rd), 128'h0);
    compl(3'd1);
    reg_rd(11'h008, rd); chk("busy_after_compl", 128'(rd), 128'h0);
    chk("single_push_count", 128'(pq.size()), 128'd1);

    // round robin from reset pointer
    do_reset();
    reg_wr(11'h000, 32'hF);
    wait_pushes(4, "rr4_count");
    for (int i = 0; i < 4; i++)
      if (pq.size() > i) chk("rr4_order", 128'(pq[i][73:71]), 128'(i));
    reg_rd(11'h008, rd); chk("rr4_busy", 128'(rd), 128'hF);
    compl(3'd0); compl(3'd1); compl(3'd2);
    reg_rd(11'h008, rd); chk("rr_busy_left", 128'(rd), 128'h8);
    pq.delete();
    reg_wr(11'h000, 32'h2);
    wait_pushes(1, "rr_ch1_count");
    if (pq.size() > 0) chk("rr_ch1", 128'(pq[0][73:71]), 128'd1);
    reg_wr(11'h000, 32'h5);
    wait_pushes(3, "rr_wrap_count");
    if (pq.size() > 2) begin
      chk("rr_wrap_first", 128'(pq[1][73:71]), 128'd2);
      chk("rr_wrap_second", 128'(pq[2][73:71]), 128'd0);
    end
    // doorbell on a busy channel is dropped
    reg_wr(11'h000, 32'h8);
    repeat (4) @(negedge clk);
    reg_rd(11'h00C, rd); chk("busy_db_ignored", 128'(rd), 128'h0);
    chk("busy_db_no_push", 128'(pq.size()), 128'd3);

    // completion held off by a full FIFO
    pq.delete();
    cpl_fields = {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i,
                  req_rid_i, req_tag_i, req_be_i, req_addr_i[5:0]};
    @(negedge clk);
    us_cmd_fifo_full_i = 1'b1; req_compl_i = 1'b1; req_compl_with_data_i = 1'b1;
    @(negedge clk);
    req_compl_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("cpl_wait_busy", 128'(wr_busy_o), 128'd1);
      chk("cpl_wait_no_push", 128'(us_cmd_fifo_wr_en_o), 128'd0);
      @(negedge clk);
    end
    us_cmd_fifo_full_i = 1'b0;
    @(negedge clk);
    chk("cpld_push", 128'(us_cmd_fifo_wr_en_o), 128'd1);
    chk("cpld_done", 128'(to_rxe_compl_done_o), 128'd1);
    exp_word = {54'd0, 3'd0, 5'd6, 2'd3, 9'd0, cpl_fields};
    chk("cpld_word", us_cmd_fifo_din_o, exp_word);
    @(negedge clk);
    chk("cpld_done_one_cycle", 128'(to_rxe_compl_done_o), 128'd0);
    chk("cpld_idle", 128'(wr_busy_o), 128'd0);
    chk("cpld_single_push", 128'(pq.size()), 128'd1);

    // completion beats an already pending command
    pq.delete();
    compl(3'd3);
    us_cmd_fifo_prog_full_i = 1'b1;
    reg_wr(11'h000, 32'h8);
    reg_rd(11'h00C, rd); chk("prio_pending_held", 128'(rd), 128'h8);
    chk("prio_prog_full_no_push", 128'(pq.size()), 128'd0);
    @(negedge clk);
    req_compl_i = 1'b1; req_compl_with_data_i = 1'b0; us_cmd_fifo_prog_full_i = 1'b0;
    @(negedge clk);
    req_compl_i = 1'b0;
    wait_pushes(2, "prio_count");
    if (pq.size() > 1) begin
      chk("prio_first_cpl", 128'(pq[0][65:64]), 128'd2);
      chk("prio_second_wr", 128'(pq[1][65:64]), 128'd1);
      chk("prio_second_ch3", 128'(pq[1][73:71]), 128'd3);
    end

    // same-cycle completion and doorbell on ch3
    pq.delete();
    @(negedge clk);
    up_wr_cmd_compl_i = 1'b1; cmd_id_i = 3'd3;
    wr_addr_i = 11'h000; wr_data_i = 32'h8; wr_en_i = 1'b1;
    @(negedge clk);
    up_wr_cmd_compl_i = 1'b0; wr_en_i = 1'b0;
    wait_pushes(1, "race_count");
    if (pq.size() > 0) chk("race_ch3", 128'(pq[0][73:71]), 128'd3);
    reg_rd(11'h008, rd); chk("race_busy", 128'(rd), 128'hF);
    compl(3'd5);
    reg_rd(11'h008, rd); chk("compl_id_oob", 128'(rd), 128'hF);
    for (int i = 0; i < 4; i++) compl(3'(i));
    reg_rd(11'h008, rd); chk("all_compl", 128'(rd), 128'h0);

    // reset asserted while a command word is on the FIFO port
    reg_wr(11'h020, 32'h55AA_0000);
    reg_wr(11'h004, 32'h9);
    reg_wr(11'h000, 32'h1);
    @(negedge clk);
    chk("pre_rst_push", 128'(us_cmd_fifo_wr_en_o), 128'd1);
    rst = 1'b1;
    #1;
    chk("rst_push_drop", 128'(us_cmd_fifo_wr_en_o), 128'd0);
    chk("rst_din_drop", us_cmd_fifo_din_o, 128'd0);
    chk("rst_busy_drop", 128'(wr_busy_o), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    pq.delete();
    reg_rd(11'h004, rd); chk("post_rst_len", 128'(rd), 128'h6);
    reg_rd(11'h008, rd); chk("post_rst_busy", 128'(rd), 128'h0);
    reg_rd(11'h00C, rd); chk("post_rst_pending", 128'(rd), 128'h0);
    reg_rd(11'h020, rd); chk("post_rst_addr0", 128'(rd), 128'h0);
    repeat (4) @(negedge clk);
    chk("post_rst_no_push", 128'(pq.size()), 128'd0);

    chk("din_zero_without_push", 128'(din_bad), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
